// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the RV32I five-stage pipeline: captures decoded
// operands/control, forwards from MEM/WB, and inserts load-use bubbles.
module id_ex_reg #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [3:0]      id_alu_op,
  input  logic [2:0]      id_branch,
  input  logic            id_is_branch,
  input  logic            id_alu_src_imm,
  input  logic            id_alu_src_pc,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic [2:0]      id_funct3,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output logic            ex_is_branch,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd,
  output logic [3:0]      ex_alu_op,
  output logic [2:0]      ex_branch,
  output logic [2:0]      ex_funct3,
  output logic [XLEN-1:0] ex_alu_a,
  output logic [XLEN-1:0] ex_alu_b,
  output logic [XLEN-1:0] ex_store_data,
  output logic            load_use_hazard
);

  logic [RA_W-1:0] rs1_q, rs2_q;
  logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q;
  logic            alu_src_imm_q, alu_src_pc_q;
  logic [XLEN-1:0] fwd1, fwd2;
  logic            bubble;

  // MEM beats WB; x0 never forwards so the register file's zero is kept.
  always_comb begin
    fwd1 = rs1_data_q;
    if (mem_reg_write && mem_rd != '0 && mem_rd == rs1_q)
      fwd1 = mem_result;
    else if (wb_reg_write && wb_rd != '0 && wb_rd == rs1_q)
      fwd1 = wb_result;
  end

  always_comb begin
    fwd2 = rs2_data_q;
    if (mem_reg_write && mem_rd != '0 && mem_rd == rs2_q)
      fwd2 = mem_result;
    else if (wb_reg_write && wb_rd != '0 && wb_rd == rs2_q)
      fwd2 = wb_result;
  end

  assign ex_alu_a      = alu_src_pc_q  ? ex_pc : fwd1;
  assign ex_alu_b      = alu_src_imm_q ? imm_q : fwd2;
  assign ex_store_data = fwd2;

  assign load_use_hazard = ex_valid && ex_mem_read && ex_rd != '0 && id_valid &&
                           (id_rs1 == ex_rd || id_rs2 == ex_rd);

  // Stall outranks the load-use bubble, so the hazard only clears EX when not stalled.
  assign bubble = rst || flush || (!stall && load_use_hazard);

  always_ff @(posedge clk) begin
    if (bubble) begin
      ex_valid      <= 1'b0;
      ex_is_branch  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_pc         <= '0;
      ex_rd         <= '0;
      ex_alu_op     <= '0;
      ex_branch     <= '0;
      ex_funct3     <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      alu_src_imm_q <= 1'b0;
      alu_src_pc_q  <= 1'b0;
    end else if (stall) begin
      // Absorb any retiring writeback so it survives the source leaving the pipe.
      rs1_data_q <= fwd1;
      rs2_data_q <= fwd2;
    end else begin
      ex_valid      <= id_valid;
      ex_is_branch  <= id_is_branch;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_pc         <= id_pc;
      ex_rd         <= id_rd;
      ex_alu_op     <= id_alu_op;
      ex_branch     <= id_branch;
      ex_funct3     <= id_funct3;
      rs1_q         <= id_rs1;
      rs2_q         <= id_rs2;
      rs1_data_q    <= id_rs1_data;
      rs2_data_q    <= id_rs2_data;
      imm_q         <= id_imm;
      alu_src_imm_q <= id_alu_src_imm;
      alu_src_pc_q  <= id_alu_src_pc;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the EX slot.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic [2:0]  id_branch, id_funct3;
  logic        id_is_branch, id_alu_src_imm, id_alu_src_pc;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid, ex_is_branch, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] ex_pc, ex_alu_a, ex_alu_b, ex_store_data;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_branch, ex_funct3;
  logic        load_use_hazard;

  int checks;
  int errors;
  bit ready;
  bit finished;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_branch(id_branch), .id_is_branch(id_is_branch),
    .id_alu_src_imm(id_alu_src_imm), .id_alu_src_pc(id_alu_src_pc),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_funct3(id_funct3),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
    .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_store_data(ex_store_data),
    .load_use_hazard(load_use_hazard)
  );

  // Model of the instruction occupying EX; an all-zero record is a bubble.
  typedef struct packed {
    logic        valid, is_branch, reg_write, mem_read, mem_write, src_imm, src_pc;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic [2:0]  br, f3;
  } ex_t;

  ex_t m;

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] held);
    if (idx == 5'd0) return held;
    if (mem_reg_write && mem_rd == idx) return mem_result;
    if (wb_reg_write && wb_rd == idx) return wb_result;
    return held;
  endfunction

  function automatic logic hazardExp();
    return m.valid && m.mem_read && m.rd != 5'd0 && id_valid &&
           (id_rs1 == m.rd || id_rs2 == m.rd);
  endfunction

  always @(posedge clk) begin
    logic hz;
    if (rst) ready = 1'b1;
    if (ready) begin
      hz = hazardExp();
      if (rst || flush) m = '0;
      else if (stall) begin
        m.d1 = fwd(m.rs1, m.d1);
        m.d2 = fwd(m.rs2, m.d2);
      end else if (hz) m = '0;
      else begin
        m.valid = id_valid;     m.is_branch = id_is_branch; m.reg_write = id_reg_write;
        m.mem_read = id_mem_read; m.mem_write = id_mem_write;
        m.src_imm = id_alu_src_imm; m.src_pc = id_alu_src_pc;
        m.pc = id_pc; m.d1 = id_rs1_data; m.d2 = id_rs2_data; m.imm = id_imm;
        m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
        m.op = id_alu_op; m.br = id_branch; m.f3 = id_funct3;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ready && !finished) begin
      checkOutput("m_valid",     32'(ex_valid),        32'(m.valid));
      checkOutput("m_is_branch", 32'(ex_is_branch),    32'(m.is_branch));
      checkOutput("m_reg_write", 32'(ex_reg_write),    32'(m.reg_write));
      checkOutput("m_mem_read",  32'(ex_mem_read),     32'(m.mem_read));
      checkOutput("m_mem_write", 32'(ex_mem_write),    32'(m.mem_write));
      checkOutput("m_pc",        ex_pc,                m.pc);
      checkOutput("m_rd",        32'(ex_rd),           32'(m.rd));
      checkOutput("m_alu_op",    32'(ex_alu_op),       32'(m.op));
      checkOutput("m_branch",    32'(ex_branch),       32'(m.br));
      checkOutput("m_funct3",    32'(ex_funct3),       32'(m.f3));
      checkOutput("m_alu_a",     ex_alu_a,      m.src_pc  ? m.pc  : fwd(m.rs1, m.d1));
      checkOutput("m_alu_b",     ex_alu_b,      m.src_imm ? m.imm : fwd(m.rs2, m.d2));
      checkOutput("m_store",     ex_store_data, fwd(m.rs2, m.d2));
      checkOutput("m_hazard",    32'(load_use_hazard), 32'(hazardExp()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    rst = 0; stall = 0; flush = 0; id_valid = 0;
    id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_op = 0; id_branch = 0; id_funct3 = 0;
    id_is_branch = 0; id_alu_src_imm = 0; id_alu_src_pc = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  // Small register range so forwarding and load-use matches happen often.
  task automatic applyStimulus();
    rst   = ($urandom_range(49) == 0);
    flush = ($urandom_range(9) == 0);
    stall = ($urandom_range(5) == 0);
    id_valid = ($urandom_range(3) != 0);
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1 = 5'($urandom_range(7)); id_rs2 = 5'($urandom_range(7));
    id_rd = 5'($urandom_range(7));
    id_alu_op = 4'($urandom_range(9)); id_branch = 3'($urandom_range(7));
    id_funct3 = 3'($urandom_range(7));
    id_is_branch = 1'($urandom); id_alu_src_imm = 1'($urandom);
    id_alu_src_pc = 1'($urandom); id_reg_write = 1'($urandom);
    id_mem_read = ($urandom_range(2) == 0); id_mem_write = 1'($urandom);
    mem_reg_write = 1'($urandom); mem_rd = 5'($urandom_range(7)); mem_result = $urandom;
    wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(7)); wb_result = $urandom;
  endtask

  initial begin
    checks = 0; errors = 0; ready = 0; finished = 0;
    clearInputs();
    rst = 1;
    tick();
    rst = 0;
    checkOutput("rst_valid",  32'(ex_valid),        32'd0);
    checkOutput("rst_alu_a",  ex_alu_a,             32'd0);
    checkOutput("rst_hazard", 32'(load_use_hazard), 32'd0);

    // add x3 = x1 + x2
    id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 3; id_rs1_data = 5; id_rs2_data = 7;
    id_reg_write = 1; id_pc = 32'h100;
    tick(); clearInputs();
    checkOutput("basic_valid", 32'(ex_valid),  32'd1);
    checkOutput("basic_op",    32'(ex_alu_op), 32'd0);
    checkOutput("basic_a",     ex_alu_a,       32'd5);
    checkOutput("basic_b",     ex_alu_b,       32'd7);
    checkOutput("basic_rd",    32'(ex_rd),     32'd3);

    // forwarding priority on rs1 = 4
    id_valid = 1; id_rs1 = 4; id_rs1_data = 32'h99; id_rd = 8;
    tick(); clearInputs();
    mem_reg_write = 1; mem_rd = 4; mem_result = 32'h11;
    wb_reg_write = 1; wb_rd = 4; wb_result = 32'h22;
    #1 checkOutput("fwd_mem", ex_alu_a, 32'h11);
    mem_reg_write = 0;
    #1 checkOutput("fwd_wb", ex_alu_a, 32'h22);
    clearInputs();
    id_valid = 1; id_rs1 = 0; id_rs1_data = 32'h33;
    mem_reg_write = 1; mem_rd = 0; mem_result = 32'h44;
    wb_reg_write = 1; wb_rd = 0; wb_result = 32'h55;
    tick();
    checkOutput("fwd_x0", ex_alu_a, 32'h33);
    clearInputs();

    // lw x5 followed by add x6 = x5 + x1
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5; id_rs1 = 2; id_funct3 = 3'd2;
    tick(); clearInputs();
    id_valid = 1; id_rs1 = 5; id_rs2 = 1; id_rd = 6; id_rs2_data = 3; id_reg_write = 1;
    #1 checkOutput("lu_hazard", 32'(load_use_hazard), 32'd1);
    tick();
    checkOutput("lu_bubble_valid", 32'(ex_valid),        32'd0);
    checkOutput("lu_bubble_rw",    32'(ex_reg_write),    32'd0);
    checkOutput("lu_bubble_mr",    32'(ex_mem_read),     32'd0);
    checkOutput("lu_clear",        32'(load_use_hazard), 32'd0);
    mem_reg_write = 1; mem_rd = 5; mem_result = 32'hAB;
    tick();
    checkOutput("lu_valid", 32'(ex_valid), 32'd1);
    checkOutput("lu_fwd_a", ex_alu_a,      32'hAB);
    clearInputs();

    // stall refresh of rs2 = 7
    id_valid = 1; id_rs2 = 7; id_rs2_data = 1; id_rd = 9; id_reg_write = 1;
    tick(); clearInputs();
    checkOutput("st_pre_b", ex_alu_b, 32'd1);
    stall = 1; wb_reg_write = 1; wb_rd = 7; wb_result = 9;
    #1 checkOutput("st_c1_b", ex_alu_b, 32'd9);
    tick();
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
    #1 checkOutput("st_c2_b", ex_alu_b, 32'd9);
    tick();
    stall = 0;
    checkOutput("st_post_b",     ex_alu_b,     32'd9);
    checkOutput("st_post_valid", 32'(ex_valid), 32'd1);
    checkOutput("st_post_rd",    32'(ex_rd),    32'd9);

    // flush beats stall on a valid sw
    id_valid = 1; id_mem_write = 1; id_rs1 = 2; id_rs2 = 3; id_funct3 = 3'd2;
    tick(); clearInputs();
    checkOutput("fs_pre_mw", 32'(ex_mem_write), 32'd1);
    flush = 1; stall = 1;
    tick(); clearInputs();
    checkOutput("fs_valid", 32'(ex_valid),     32'd0);
    checkOutput("fs_mw",    32'(ex_mem_write), 32'd0);

    repeat (3000) begin
      applyStimulus();
      tick();
    end

    // reset together with stall after traffic
    applyStimulus();
    rst = 1; stall = 1;
    tick(); clearInputs();
    checkOutput("rs_valid",  32'(ex_valid),        32'd0);
    checkOutput("rs_pc",     ex_pc,                32'd0);
    checkOutput("rs_rd",     32'(ex_rd),           32'd0);
    checkOutput("rs_op",     32'(ex_alu_op),       32'd0);
    checkOutput("rs_mr",     32'(ex_mem_read),     32'd0);
    checkOutput("rs_a",      ex_alu_a,             32'd0);
    checkOutput("rs_b",      ex_alu_b,             32'd0);
    checkOutput("rs_hazard", 32'(load_use_hazard), 32'd0);

    finished = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
